fixed_float_conv_arbiter: RTL and testbench
===========================================

Name: fixed_float_conv_arbiter

Overview:
- Shares one Fixed_Float_Conversion instance (22-bit fixed in, 32-bit IEEE-754 out, enable/done handshake) between N_REQ requesters using round-robin arbitration.
- Latches the granted requester's operand and drives the converter's enable/data. It waits for done, returns the result to the owner, and then waits for done to drop before the next issue.
- A watchdog guards against a converter that never completes.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- TIMEOUT, 32, max cycles spent in ISSUE or RELEASE before forced exit (≥4).
- IDW, 2, requester index width; must equal clog2(N_REQ).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req  in  N_REQ  level request per requester; held until its rsp_valid.
- req_data  in  22*N_REQ  operand for requester i at bits [22*i+21:22*i]; stable while req[i] is high.
- rsp_valid  out  N_REQ  one-hot, one-cycle pulse to the owning requester.
- rsp_result  out  32  float result, valid with rsp_valid.
- rsp_error  out  1  high with rsp_valid on a timeout.
- rsp_id  out  IDW  index of the responding requester, valid with rsp_valid.
- busy  out  1  high in any state other than IDLE.
- conv_data  out  22  operand to the converter.
- conv_enable  out  1  converter enable.
- conv_done  in  1  converter done.
- conv_result  in  32  converter result.

Behaviour:
- Reset, asynchronous and applied at any time including mid-conversion:
  - state=IDLE, ptr=0, timer=0.
  - rsp_valid=0, rsp_result=0, rsp_error=0, rsp_id=0, conv_data=0, conv_enable=0, busy=0.
  - Dropping conv_enable causes the converter to clear done on its next edge. No response is issued for an aborted conversion.
- All outputs are registered.
- Arbitration:
  - Scan req starting at index ptr, wrapping modulo N_REQ. The first set bit wins.
  - On a grant, ptr <= (grant+1) mod N_REQ. Simultaneous requests are served in rotating order.
- State IDLE:
  - If any req is high, latch grant into gid and latch req_data[gid] into conv_data.
  - Set conv_enable <= 1, timer <= 0, go to ISSUE.
- State ISSUE:
  - timer increments each cycle.
  - If conv_done is sampled high: rsp_result <= conv_result, rsp_error <= 0, rsp_valid[gid] <= 1, rsp_id <= gid, conv_enable <= 0, timer <= 0, go to RELEASE.
  - Else if timer == TIMEOUT-1: same transition, but rsp_result <= 0 and rsp_error <= 1.
- State RELEASE:
  - rsp_valid clears after one cycle.
  - Stay until conv_done is sampled low, then go to IDLE.
  - If timer reaches TIMEOUT-1 first, go to IDLE anyway (stuck-done recovery). No further response is issued.
- Latency with a one-cycle converter:
  - e0: grant edge, conv_enable rises.
  - e1: converter asserts done.
  - e2: rsp_valid rises.
  - e4: back in IDLE.
  - e5: earliest next grant.
- Requester rules:
  - A requester must drop req in the cycle after its rsp_valid.
  - A req still high when the arbiter re-enters IDLE is treated as a new request. Its rotated priority still applies.
- req changes during ISSUE/RELEASE do not affect the in-flight operation. The operand was latched at grant.
- Zero operand: no special casing. The converter returns 0x00000000 and it is forwarded unchanged.
- rsp_valid is never asserted for more than one requester or for more than one cycle per grant.

Test Plan:
- Single request: req=4'b0001, req_data[21:0]=22'h100000 (+1.0) → conv_data=22'h100000; rsp_valid=4'b0001 two edges after the grant; rsp_result=32'h3F800000; rsp_error=0; rsp_id=0.
- Contention: req=4'b1011 from reset (ptr=0) → responses in order id 0, 1, 3. Each requester drops req after its pulse. Then ptr=0.
- Fairness wrap: after id 3 is served, req=4'b1001 → id 0 is served before id 3.
- Timeout: conv_done held at 0, req=4'b0100 → rsp_valid=4'b0100 with rsp_error=1 and rsp_result=0, 32 cycles after the grant; conv_enable=0 afterwards.
- Reset mid-ISSUE: assert rst while conv_enable=1 → all outputs are 0 immediately (asynchronous) and no rsp_valid is issued. After release, a pending req is re-granted starting from ptr=0.
- Stuck done: conv_done held at 1 after a response → arbiter leaves RELEASE after TIMEOUT cycles, returns to IDLE, and accepts the next request.

Source files
------------

// File: rtl/fixed_float_conv_arbiter_if.sv
// Purpose : bundles the requester-side and converter-side signals of the
//           shared fixed->float converter arbiter into one interface.
// Latency : n/a (wiring only).
// Backpressure : none here; requesters hold req until their rsp_valid pulse.
//
// Signals:
//   req/req_data                 requester levels and packed 22-bit operands
//   rsp_valid/result/error/id    one-cycle response back to the owner
//   busy                         arbiter not idle
//   conv_data/conv_enable        operand and enable toward the converter
//   conv_done/conv_result        handshake and result from the converter
// Modports:
//   master : the arbiter (drives responses and the converter request)
//   slave  : the environment (requesters plus converter)
interface fixed_float_conv_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
);
  logic [N_REQ-1:0]    req;
  logic [22*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    rsp_valid;
  logic [31:0]         rsp_result;
  logic                rsp_error;
  logic [IDW-1:0]      rsp_id;
  logic                busy;
  logic [21:0]         conv_data;
  logic                conv_enable;
  logic                conv_done;
  logic [31:0]         conv_result;

  modport master (
    input  req, req_data, conv_done, conv_result,
    output rsp_valid, rsp_result, rsp_error, rsp_id, busy,
           conv_data, conv_enable
  );

  modport slave (
    output req, req_data, conv_done, conv_result,
    input  rsp_valid, rsp_result, rsp_error, rsp_id, busy,
           conv_data, conv_enable
  );
endinterface

// File: rtl/fixed_float_conv_arbiter.sv
// Purpose : shares one fixed->float converter between N_REQ requesters with
//           round-robin arbitration and a watchdog on the converter handshake.
// Latency : grant at e0, response pulse at e2 for a one-cycle converter,
//           back in IDLE at e4, next grant at e5.
// Backpressure : requesters hold req (and operand) until their rsp_valid;
//           one operation in flight, others wait in rotating priority order.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   bus.master   requester levels/operands in, one-hot response out, busy,
//                converter enable/operand out, converter done/result in
module fixed_float_conv_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 32,
  parameter int IDW     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  fixed_float_conv_arbiter_if.master  bus
);

  localparam int W1 = IDW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gid;
  logic [TW-1:0]  timer;

  // Round-robin pick: first requester at or after ptr, wrapping.
  logic           any_req;
  logic [IDW-1:0] gnt;
  logic [W1-1:0]  idx;
  logic [21:0]    gnt_operand;
  logic [IDW-1:0] ptr_next;
  logic [N_REQ-1:0] gid_oh;
  logic           timer_exp;

  always_comb begin
    any_req = 1'b0;
    gnt     = '0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr} + W1'(k);
      if (idx >= W1'(N_REQ)) begin
        idx = idx - W1'(N_REQ);
      end
      if (!any_req && bus.req[idx[IDW-1:0]]) begin
        any_req = 1'b1;
        gnt     = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    gnt_operand = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt == IDW'(i)) begin
        gnt_operand = bus.req_data[22*i +: 22];
      end
    end
  end

  always_comb begin
    gid_oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gid_oh[i] = (gid == IDW'(i));
    end
  end

  assign ptr_next  = (gnt == IDW'(N_REQ - 1)) ? '0 : gnt + 1'b1;
  assign timer_exp = (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      ptr             <= '0;
      gid             <= '0;
      timer           <= '0;
      bus.rsp_valid   <= '0;
      bus.rsp_result  <= '0;
      bus.rsp_error   <= 1'b0;
      bus.rsp_id      <= '0;
      bus.busy        <= 1'b0;
      bus.conv_data   <= '0;
      bus.conv_enable <= 1'b0;
    end else begin
      // Response is a single-cycle pulse regardless of state.
      bus.rsp_valid <= '0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            gid             <= gnt;
            ptr             <= ptr_next;
            bus.conv_data   <= gnt_operand;
            bus.conv_enable <= 1'b1;
            bus.busy        <= 1'b1;
            timer           <= '0;
            state           <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          timer <= timer + 1'b1;
          if (bus.conv_done) begin
            bus.rsp_result  <= bus.conv_result;
            bus.rsp_error   <= 1'b0;
            bus.rsp_valid   <= gid_oh;
            bus.rsp_id      <= gid;
            bus.conv_enable <= 1'b0;
            timer           <= '0;
            state           <= S_RELEASE;
          end else if (timer_exp) begin
            // Converter never answered: report an error result to the owner.
            bus.rsp_result  <= '0;
            bus.rsp_error   <= 1'b1;
            bus.rsp_valid   <= gid_oh;
            bus.rsp_id      <= gid;
            bus.conv_enable <= 1'b0;
            timer           <= '0;
            state           <= S_RELEASE;
          end
        end

        S_RELEASE: begin
          timer <= timer + 1'b1;
          // Wait for done to fall so the next issue cannot see a stale done;
          // give up after the watchdog period if done is stuck high.
          if (!bus.conv_done || timer_exp) begin
            timer    <= '0;
            bus.busy <= 1'b0;
            state    <= S_IDLE;
          end
        end

        default: begin
          bus.conv_enable <= 1'b0;
          bus.busy        <= 1'b0;
          timer           <= '0;
          state           <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_float_conv_arbiter.sv
module tb_fixed_float_conv_arbiter;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  // Converter model behaviour: 0 = done one cycle after enable,
  // 1 = never done, 2 = done sticks high once raised.
  int   mode;

  fixed_float_conv_arbiter_if #(.N_REQ(4), .IDW(2)) bus ();

  fixed_float_conv_arbiter #(.N_REQ(4), .TIMEOUT(32), .IDW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Signed Q1.20 fixed to IEEE-754 single.
  function automatic logic [31:0] f2f(input logic [21:0] x);
    int v;
    int mag;
    int p;
    int mant;
    logic [31:0] r;
    v = int'($signed(x));
    mag = (v < 0) ? -v : v;
    if (mag == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 23; i++) if (mag[i]) p = i;
    mant = mag << (23 - p);
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p - 20);
    r[22:0]  = mant[22:0];
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.conv_done   <= 1'b0;
      bus.conv_result <= 32'h0;
    end else begin
      case (mode)
        0: begin
          bus.conv_done   <= bus.conv_enable;
          bus.conv_result <= f2f(bus.conv_data);
        end
        1: bus.conv_done <= 1'b0;
        default: begin
          bus.conv_done   <= bus.conv_done | bus.conv_enable;
          bus.conv_result <= f2f(bus.conv_data);
        end
      endcase
    end
  end

  // Grant monitor: cycle and operand at each conv_enable rise.
  logic        prev_en;
  int          grant_cyc;
  logic [21:0] grant_dat;
  initial prev_en = 1'b0;
  always @(negedge clk) begin
    if (bus.conv_enable && !prev_en) begin
      grant_cyc = cyc;
      grant_dat = bus.conv_data;
    end
    prev_en = bus.conv_enable;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.rsp_valid != 4'b0000) begin
        ok = 1'b1;
        return;
      end
    end
    timeout_fail("wait_rsp");
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!bus.busy) return;
    end
    timeout_fail("wait_idle");
  endtask

  // Present requests and collect n responses in the given id order.
  task automatic serve(input logic [3:0] rq, input logic [3:0][21:0] dat,
                       input int n, input logic [3:0][1:0] ids,
                       input logic [3:0][31:0] res, input logic err, input int lat);
    bit ok;
    logic [1:0] id;
    logic [3:0] oh;
    bus.req_data = dat;
    bus.req      = rq;
    for (int k = 0; k < n; k++) begin
      wait_rsp(ok);
      if (!ok) return;
      id = ids[k];
      oh = 4'b0001 << id;
      check("rsp_valid", 32'(bus.rsp_valid), 32'(oh));
      check("rsp_id", 32'(bus.rsp_id), 32'(id));
      check("rsp_result", bus.rsp_result, res[k]);
      check("rsp_error", 32'(bus.rsp_error), 32'(err));
      check("latency", 32'(cyc - grant_cyc), 32'(lat));
      check("conv_data", 32'(grant_dat), 32'(dat[id]));
      bus.req[id] = 1'b0;
      @(negedge clk);
      check("rsp_pulse", 32'(bus.rsp_valid), 32'h0);
      check("conv_enable_off", 32'(bus.conv_enable), 32'h0);
    end
    wait_idle();
  endtask

  typedef struct {
    logic [3:0]        req;
    logic [3:0][21:0]  data;
    int                n;
    logic [3:0][1:0]   ids;
    logic [3:0][31:0]  res;
  } vec_t;

  vec_t tbl [5];

  initial begin
    bit ok;
    int r_cyc;
    int pulses;
    n_cmp = 0;
    n_bad = 0;
    mode  = 0;
    rst   = 1'b1;
    bus.req      = 4'b0000;
    bus.req_data = '0;

    // Contention from ptr=0, fairness wrap, single, then rotated pairs.
    tbl[0] = '{req: 4'b1011, data: {22'h000000, 22'h0, 22'h180000, 22'h080000}, n: 3,
               ids: {2'd0, 2'd3, 2'd1, 2'd0},
               res: {32'h0, 32'h00000000, 32'h3FC00000, 32'h3F000000}};
    tbl[1] = '{req: 4'b1001, data: {22'h040000, 22'h0, 22'h0, 22'h200000}, n: 2,
               ids: {2'd0, 2'd0, 2'd3, 2'd0},
               res: {32'h0, 32'h0, 32'h3E800000, 32'hC0000000}};
    tbl[2] = '{req: 4'b0001, data: {22'h0, 22'h0, 22'h0, 22'h100000}, n: 1,
               ids: {2'd0, 2'd0, 2'd0, 2'd0},
               res: {32'h0, 32'h0, 32'h0, 32'h3F800000}};
    tbl[3] = '{req: 4'b0110, data: {22'h0, 22'h000001, 22'h3FFFFF, 22'h0}, n: 2,
               ids: {2'd0, 2'd0, 2'd2, 2'd1},
               res: {32'h0, 32'h0, 32'h35800000, 32'hB5800000}};
    tbl[4] = '{req: 4'b1100, data: {22'h0C0000, 22'h1FFFFF, 22'h0, 22'h0}, n: 2,
               ids: {2'd0, 2'd0, 2'd2, 2'd3},
               res: {32'h0, 32'h0, 32'h3FFFFFF8, 32'h3F400000}};

    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_result", bus.rsp_result, 32'h0);
    check("rst_rsp_error", 32'(bus.rsp_error), 32'h0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
    check("rst_conv", {9'h0, bus.conv_enable, bus.conv_data}, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      serve(tbl[i].req, tbl[i].data, tbl[i].n, tbl[i].ids, tbl[i].res, 1'b0, 2);
      repeat (2) @(negedge clk);
    end

    // Watchdog in ISSUE: converter never completes.
    mode = 1;
    serve(4'b0100, {22'h0, 22'h100000, 22'h0, 22'h0}, 1, {2'd0, 2'd0, 2'd0, 2'd2},
          {32'h0, 32'h0, 32'h0, 32'h0}, 1'b1, 32);
    repeat (2) @(negedge clk);

    // Reset while a conversion is outstanding (ptr=3 -> id 1 granted).
    bus.req_data = {22'h0, 22'h0, 22'h0, 22'h0};
    bus.req      = 4'b0010;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = bus.conv_enable;
    end
    if (!ok) timeout_fail("wait_grant");
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_conv_enable", 32'(bus.conv_enable), 32'h0);
    check("arst_busy", 32'(bus.busy), 32'h0);
    check("arst_conv_data", 32'(bus.conv_data), 32'h0);
    check("arst_rsp", {bus.rsp_result[31:3] | 29'(bus.rsp_id), bus.rsp_error, bus.rsp_result[2:0] != 3'b0, 1'b0}, 32'h0);
    mode = 0;
    bus.req = 4'b1010;
    @(negedge clk);
    check("arst_no_rsp", 32'(bus.rsp_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    // ptr restarted at 0, so id 1 wins ahead of id 3.
    serve(4'b1010, {22'h180000, 22'h0, 22'h0C0000, 22'h0}, 2, {2'd0, 2'd0, 2'd3, 2'd1},
          {32'h0, 32'h0, 32'h3FC00000, 32'h3F400000}, 1'b0, 2);
    repeat (2) @(negedge clk);

    // Stuck done: RELEASE must give up after the watchdog period.
    mode = 2;
    bus.req_data = {22'h0, 22'h0, 22'h0, 22'h100000};
    bus.req      = 4'b0001;
    wait_rsp(ok);
    if (ok) begin
      check("stuck_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      check("stuck_rsp_result", bus.rsp_result, 32'h3F800000);
      r_cyc = cyc;
      bus.req = 4'b0000;
      pulses = 0;
      ok = 1'b0;
      for (int n = 0; n < 100 && !ok; n++) begin
        @(negedge clk);
        if (bus.rsp_valid != 4'b0000) pulses++;
        ok = !bus.busy;
      end
      if (!ok) timeout_fail("stuck_exit");
      check("stuck_exit_cycles", 32'(cyc - r_cyc), 32'd32);
      check("stuck_no_extra_rsp", 32'(pulses), 32'h0);
    end
    mode = 0;
    repeat (3) @(negedge clk);
    serve(4'b0100, {22'h0, 22'h080000, 22'h0, 22'h0}, 1, {2'd0, 2'd0, 2'd0, 2'd2},
          {32'h0, 32'h0, 32'h0, 32'h3F000000}, 1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
